// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults and next-PC select encoding for the program-counter unit.
package pc_pkg;
   localparam int PC_ADDR_W    = 8;
   localparam int PC_STEP      = 1;
   localparam int PC_RESET_VEC = 0;
   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_INC,
      SEL_JUMP,
      SEL_CALL,
      SEL_RET
   } pc_sel_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with sticky overflow/underflow flags.
//   clk, rst        : clock, synchronous active-high reset
//   push, pop       : stack requests (never both asserted by the top)
//   push_data       : return address to push
//   top             : newest entry
//   count           : valid entries (saturates at DEPTH)
//   overflow        : sticky, push while full
//   underflow       : sticky, pop while empty
module pc_ras
   import pc_pkg::*;
#(
   parameter int ADDR_W = PC_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [ADDR_W-1:0]        push_data,
   output logic [ADDR_W-1:0]        top,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int PW = $clog2(DEPTH);
   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wp_q, wp_d;
   logic [PW:0]       cnt_q, cnt_d;
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic              full, empty, do_pop;
   assign full   = cnt_q == (PW+1)'(DEPTH);
   assign empty  = cnt_q == '0;
   assign do_pop = pop && !push && !empty;
   always_comb begin
      wp_d  = push ? wp_q + 1'b1 : do_pop ? wp_q - 1'b1 : wp_q;
      // a push onto a full stack overwrites the oldest slot, so the count saturates
      cnt_d = push ? (full ? cnt_q : cnt_q + 1'b1) : do_pop ? cnt_q - 1'b1 : cnt_q;
      ovf_d = ovf_q | (push & full);
      udf_d = udf_q | (pop & !push & empty);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end
   always_ff @(posedge clk)
      if (!rst && push) mem_q[wp_q] <= push_data;
   assign top       = mem_q[wp_q - 1'b1];
   assign count     = cnt_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;
endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: parametrised PC with jump/call/ret redirection, return-address stack and PC history.
//   clk, rst                 : clock, synchronous active-high reset
//   enable                   : advance PC by STEP when no redirect
//   jump, jump_addr          : load jump target (highest priority)
//   call, call_addr          : push pc+STEP, load call target
//   ret                      : pop RAS top into PC
//   pc                       : current PC
//   pc_hist                  : slice k-1 holds PC delayed k cycles
//   ras_count                : valid RAS entries
//   ras_overflow/underflow   : sticky RAS error flags
module pc_unit_ras
   import pc_pkg::*;
#(
   parameter int ADDR_W     = PC_ADDR_W,
   parameter int STEP       = PC_STEP,
   parameter int HIST_DEPTH = 2,
   parameter int RAS_DEPTH  = 4,
   parameter int RESET_VEC  = PC_RESET_VEC
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         jump,
   input  logic [ADDR_W-1:0]            jump_addr,
   input  logic                         call,
   input  logic [ADDR_W-1:0]            call_addr,
   input  logic                         ret,
   output logic [ADDR_W-1:0]            pc,
   output logic [ADDR_W*HIST_DEPTH-1:0] pc_hist,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_overflow,
   output logic                         ras_underflow
);
   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
   pc_sel_e           sel;
   logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ras_top;
   logic [ADDR_W-1:0] hist_q [HIST_DEPTH];
   assign pc_inc = pc_q + ADDR_W'(STEP);
   always_comb begin
      sel  = jump ? SEL_JUMP : call ? SEL_CALL : ret ? SEL_RET : enable ? SEL_INC : SEL_HOLD;
      // a ret on an empty stack holds the PC; the stack raises underflow
      pc_d = sel == SEL_JUMP ? jump_addr :
             sel == SEL_CALL ? call_addr :
             (sel == SEL_RET && ras_count != '0) ? ras_top :
             sel == SEL_INC  ? pc_inc : pc_q;
   end
   pc_ras #(.ADDR_W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (sel == SEL_CALL),
      .pop       (sel == SEL_RET),
      .push_data (pc_inc),
      .top       (ras_top),
      .count     (ras_count),
      .overflow  (ras_overflow),
      .underflow (ras_underflow)
   );
   always_ff @(posedge clk)
      pc_q <= rst ? RST_PC : pc_d;
   for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_hist
      always_ff @(posedge clk)
         hist_q[k] <= rst ? RST_PC : (k == 0) ? pc_q : hist_q[(k == 0) ? 0 : k-1];
      assign pc_hist[k*ADDR_W +: ADDR_W] = hist_q[k];
   end
   assign pc = pc_q;
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed plan plus randomized stimulus against a queue-based reference model.
module tb_pc_unit_ras;
   logic       clk = 1'b0;
   logic       rst, enable, jump, call, ret;
   logic [7:0] jump_addr, call_addr, pc;
   logic [15:0] pc_hist;
   logic [2:0] ras_count;
   logic       ras_overflow, ras_underflow;
   int         n_chk = 0, n_fail = 0;
   int         m_pc, m_h0, m_h1;
   int         m_ras[$];
   bit         m_ovf, m_udf;

   always #5 clk = ~clk;

   pc_unit_ras #(.ADDR_W(8), .STEP(1), .HIST_DEPTH(2), .RAS_DEPTH(4), .RESET_VEC(0)) dut (
      .clk(clk), .rst(rst), .enable(enable), .jump(jump), .jump_addr(jump_addr),
      .call(call), .call_addr(call_addr), .ret(ret), .pc(pc), .pc_hist(pc_hist),
      .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit e, input bit j, input int ja,
                        input bit c, input int ca, input bit rt);
      if (r) begin
         m_pc = 0; m_h0 = 0; m_h1 = 0; m_ras.delete(); m_ovf = 0; m_udf = 0;
      end else begin
         m_h1 = m_h0;
         m_h0 = m_pc;
         if (j) m_pc = ja;
         else if (c) begin
            if (m_ras.size() == 4) begin
               void'(m_ras.pop_front());
               m_ovf = 1;
            end
            m_ras.push_back((m_pc + 1) % 256);
            m_pc = ca;
         end else if (rt) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else m_udf = 1;
         end else if (e) m_pc = (m_pc + 1) % 256;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit j, input int ja,
                       input bit c, input int ca, input bit rt);
      rst = r; enable = e; jump = j; jump_addr = 8'(ja); call = c; call_addr = 8'(ca); ret = rt;
      @(posedge clk);
      model(r, e, j, ja, c, ca, rt);
      #1;
      check("pc", pc, m_pc);
      check("hist0", pc_hist[7:0], m_h0);
      check("hist1", pc_hist[15:8], m_h1);
      check("ras_count", ras_count, m_ras.size());
      check("ras_overflow", ras_overflow, m_ovf);
      check("ras_underflow", ras_underflow, m_udf);
   endtask

   initial begin
      step(1, 0, 0, 0, 0, 0, 0);
      check("reset_pc", pc, 0);
      // count then stall
      repeat (3) step(0, 1, 0, 0, 0, 0, 0);
      check("inc_pc", pc, 3);
      check("inc_hist0", pc_hist[7:0], 2);
      check("inc_hist1", pc_hist[15:8], 1);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      check("stall_pc", pc, 3);
      check("stall_hist0", pc_hist[7:0], 3);
      // wrap
      step(0, 0, 1, 'hFE, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0, 0, 0, 0);
      check("wrap_pc", pc, 1);
      // call / enable / ret
      step(0, 0, 1, 10, 0, 0, 0);
      step(0, 1, 0, 0, 1, 40, 0);
      check("call_pc", pc, 40);
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1);
      check("ret_pc", pc, 11);
      check("ret_count", ras_count, 0);
      // nested calls overflow, then unwind past empty
      for (int k = 1; k <= 5; k++) begin
         step(0, 0, 1, k, 0, 0, 0);
         step(0, 0, 0, 0, 1, 19 + k, 0);
      end
      check("nest_ovf", ras_overflow, 1);
      check("nest_count", ras_count, 4);
      for (int k = 6; k >= 3; k--) begin
         step(0, 1, 0, 0, 0, 0, 1);
         check("nest_ret", pc, k);
      end
      step(0, 1, 0, 0, 0, 0, 1);
      check("udf_pc", pc, 3);
      check("udf_flag", ras_underflow, 1);
      // reset mid-sequence with stack partly full and flags set
      repeat (3) step(0, 0, 0, 0, 1, 7, 0);
      check("pre_rst_count", ras_count, 3);
      step(1, 1, 1, 9, 1, 9, 1);
      check("rst_pc", pc, 0);
      check("rst_count", ras_count, 0);
      check("rst_flags", {ras_overflow, ras_underflow}, 0);
      check("rst_hist", pc_hist, 0);
      // simultaneous requests
      step(0, 0, 1, 80, 1, 33, 0);
      check("jc_pc", pc, 80);
      check("jc_count", ras_count, 0);
      step(0, 0, 0, 0, 1, 60, 0);
      step(0, 0, 0, 0, 1, 50, 1);
      check("cr_pc", pc, 50);
      check("cr_count", ras_count, 2);
      // randomized traffic
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 7) == 0, $urandom_range(0, 255),
              $urandom_range(0, 4) == 0, $urandom_range(0, 255),
              $urandom_range(0, 3) == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
